// File: rtl/vx_amo_pkg.sv
// Shared types for the AMO read-modify-write engine: op encoding, FSM states, op classification.
package vx_amo_pkg;

    typedef enum logic [3:0] {
        AMO_ADD  = 4'd0,
        AMO_SWAP = 4'd1,
        AMO_XOR  = 4'd2,
        AMO_OR   = 4'd3,
        AMO_AND  = 4'd4,
        AMO_MIN  = 4'd5,
        AMO_MAX  = 4'd6,
        AMO_MINU = 4'd7,
        AMO_MAXU = 4'd8,
        AMO_LR   = 4'd9,
        AMO_SC   = 4'd10
    } amo_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_WR,
        ST_RSP
    } amo_state_t;

    localparam int AMO_OP_W = 4;

    // Ops ADD..MAXU write a combined value back; everything above them never does after a read.
    function automatic logic amo_is_rmw(input logic [AMO_OP_W-1:0] op);
        return op <= AMO_MAXU;
    endfunction

endpackage

// File: rtl/vx_amo_op_alu.sv
// Combinational AMO combine: new = f(op, old, operand). Ties in min/max keep the old value.
module vx_amo_op_alu
    import vx_amo_pkg::*;
(
    input  logic [AMO_OP_W-1:0] op_i,
    input  logic [31:0]         old_i,
    input  logic [31:0]         operand_i,
    output logic [31:0]         new_o
);

    always_comb begin
        new_o = old_i;
        case (op_i)
            AMO_ADD:  new_o = old_i + operand_i;
            AMO_SWAP: new_o = operand_i;
            AMO_XOR:  new_o = old_i ^ operand_i;
            AMO_OR:   new_o = old_i | operand_i;
            AMO_AND:  new_o = old_i & operand_i;
            AMO_MIN:  if ($signed(operand_i) < $signed(old_i)) new_o = operand_i;
            AMO_MAX:  if ($signed(operand_i) > $signed(old_i)) new_o = operand_i;
            AMO_MINU: if (operand_i < old_i) new_o = operand_i;
            AMO_MAXU: if (operand_i > old_i) new_o = operand_i;
            default:  new_o = old_i;
        endcase
    end

endmodule

// File: rtl/vx_amo_rmw_engine.sv
// AMO responder: one atomic read-modify-write at a time against a single-word memory port.
// Define AMO_LRSC_EN for the one-entry LR/SC reservation; without it LR and SC act as illegal ops.
module vx_amo_rmw_engine
    import vx_amo_pkg::*;
#(
    parameter int CORE_ID   = 0,
    parameter int TAG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_op,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_data,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic [TAG_WIDTH-1:0] rsp_tag,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_rw,
    output logic [29:0]          mem_req_addr,
    output logic [31:0]          mem_req_data,
    input  logic                 mem_rsp_valid,
    output logic                 mem_rsp_ready,
    input  logic [31:0]          mem_rsp_data
);

    amo_state_t           state_q;
    logic [3:0]           op_q;
    logic [29:0]          addr_q;
    logic [31:0]          operand_q;
    logic [31:0]          old_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [31:0]          alu_new_d;
`ifdef AMO_LRSC_EN
    logic                 resv_valid_q;
    logic [29:0]          resv_addr_q;
`endif

    // Byte offset is meaningless for word AMOs; CORE_ID only tags trace output elsewhere.
    logic unused_ok;
    assign unused_ok = ^{req_addr[1:0], 32'(CORE_ID)};

    vx_amo_op_alu u_alu (
        .op_i      (op_q),
        .old_i     (mem_rsp_data),
        .operand_i (operand_q),
        .new_o     (alu_new_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            addr_q        <= '0;
            operand_q     <= '0;
            old_q         <= '0;
            tag_q         <= '0;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_tag       <= '0;
            mem_req_valid <= 1'b0;
            mem_req_rw    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
            mem_rsp_ready <= 1'b0;
`ifdef AMO_LRSC_EN
            resv_valid_q  <= 1'b0;
            resv_addr_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready    <= 1'b0;
                        op_q         <= req_op;
                        addr_q       <= req_addr[31:2];
                        operand_q    <= req_data;
                        tag_q        <= req_tag;
                        old_q        <= '0;
                        mem_req_addr <= req_addr[31:2];
`ifdef AMO_LRSC_EN
                        // SC never reads: it either writes straight away or answers "fail" at once.
                        if (req_op == AMO_SC) begin
                            resv_valid_q <= 1'b0;
                            if (resv_valid_q && (resv_addr_q == req_addr[31:2])) begin
                                mem_req_valid <= 1'b1;
                                mem_req_rw    <= 1'b1;
                                mem_req_data  <= req_data;
                                state_q       <= ST_WR;
                            end else begin
                                rsp_valid <= 1'b1;
                                rsp_data  <= 32'd1;
                                rsp_tag   <= req_tag;
                                state_q   <= ST_RSP;
                            end
                        end else
`endif
                        begin
                            mem_req_valid <= 1'b1;
                            mem_req_rw    <= 1'b0;
                            mem_req_data  <= '0;
                            state_q       <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_rsp_ready <= 1'b1;
                        state_q       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid && mem_rsp_ready) begin
                        mem_rsp_ready <= 1'b0;
                        old_q         <= mem_rsp_data;
                        if (amo_is_rmw(op_q)) begin
                            mem_req_valid <= 1'b1;
                            mem_req_rw    <= 1'b1;
                            mem_req_data  <= alu_new_d;
                            state_q       <= ST_WR;
`ifdef AMO_LRSC_EN
                            if (resv_valid_q && (resv_addr_q == addr_q)) resv_valid_q <= 1'b0;
`endif
                        end else begin
`ifdef AMO_LRSC_EN
                            if (op_q == AMO_LR) begin
                                resv_valid_q <= 1'b1;
                                resv_addr_q  <= addr_q;
                            end
`endif
                            rsp_valid <= 1'b1;
                            rsp_data  <= mem_rsp_data;
                            rsp_tag   <= tag_q;
                            state_q   <= ST_RSP;
                        end
                    end
                end
                ST_WR: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_req_rw    <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_data      <= old_q;
                        rsp_tag       <= tag_q;
                        state_q       <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vx_amo_rmw_engine.sv
// Self-checking bench for vx_amo_rmw_engine: directed corner cases plus randomized AMO traffic
// checked against a word-array reference model. Honours AMO_LRSC_EN like the design.
module tb_vx_amo_rmw_engine;

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSwap = 4'd1;
    localparam logic [3:0] OpMin  = 4'd5;
    localparam logic [3:0] OpMinu = 4'd7;
    localparam logic [3:0] OpMaxu = 4'd8;
    localparam logic [3:0] OpLr   = 4'd9;
    localparam logic [3:0] OpSc   = 4'd10;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [7:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_tag;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_rw;
    logic [29:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_data;

    int checks;
    int errors;

    // Physical memory behind the port, plus a poke path so the bench can preload words.
    logic [31:0] mem [256];
    int          readCount;
    int          writeCount;
    logic        pokeEn;
    logic [7:0]  pokeAddr;
    logic [31:0] pokeData;

    // Reference model state: expected memory image and reservation.
    logic [31:0] refMem [256];
    bit          resvValid;
    logic [29:0] resvAddr;

    vx_amo_rmw_engine #(.CORE_ID(0), .TAG_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_tag       (req_tag),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_tag       (rsp_tag),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_rw    (mem_req_rw),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_data  (mem_rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait memory: a read accepted at an edge returns data during the following cycle.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_rsp_valid <= 1'b0;
            mem_rsp_data  <= '0;
        end else begin
            if (pokeEn) mem[pokeAddr] <= pokeData;
            if (mem_rsp_valid && mem_rsp_ready) mem_rsp_valid <= 1'b0;
            if (mem_req_valid && mem_req_ready) begin
                if (mem_req_rw) begin
                    mem[mem_req_addr[7:0]] <= mem_req_data;
                    writeCount <= writeCount + 1;
                end else begin
                    mem_rsp_valid <= 1'b1;
                    mem_rsp_data  <= mem[mem_req_addr[7:0]];
                    readCount     <= readCount + 1;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] refCombine(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            4'd0: return a + b;
            4'd1: return b;
            4'd2: return a ^ b;
            4'd3: return a | b;
            4'd4: return a & b;
            4'd5: return (sb < sa) ? b : a;
            4'd6: return (sb > sa) ? b : a;
            4'd7: return (b < a) ? b : a;
            4'd8: return (b > a) ? b : a;
            default: return a;
        endcase
    endfunction

    task automatic pokeWord(input logic [7:0] a, input logic [31:0] d);
        pokeAddr = a;
        pokeData = d;
        pokeEn   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pokeEn    = 1'b0;
        refMem[a] = d;
    endtask

    // One full AMO transaction; expectations come from the model before the request is issued.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [7:0] tag, input bit randomStall,
                                 output logic [31:0] rspOut);
        logic [7:0]  idx;
        logic [31:0] expRsp;
        int          expRd;
        int          expWr;
        int          rd0;
        int          wr0;
        int          n;
        bit          got;
        logic [31:0] gotData;
        logic [7:0]  gotTag;
        bit          lrsc;
`ifdef AMO_LRSC_EN
        lrsc = 1'b1;
`else
        lrsc = 1'b0;
`endif
        idx = addr[9:2];
        if (op <= 4'd8) begin
            expRsp = refMem[idx];
            refMem[idx] = refCombine(op, refMem[idx], data);
            expRd = 1;
            expWr = 1;
            if (resvValid && resvAddr == addr[31:2]) resvValid = 1'b0;
        end else if (lrsc && op == OpLr) begin
            expRsp = refMem[idx];
            expRd = 1;
            expWr = 0;
            resvValid = 1'b1;
            resvAddr = addr[31:2];
        end else if (lrsc && op == OpSc) begin
            if (resvValid && resvAddr == addr[31:2]) begin
                refMem[idx] = data;
                expRsp = 32'd0;
                expWr = 1;
            end else begin
                expRsp = 32'd1;
                expWr = 0;
            end
            expRd = 0;
            resvValid = 1'b0;
        end else begin
            expRsp = refMem[idx];
            expRd = 1;
            expWr = 0;
        end

        rd0 = readCount;
        wr0 = writeCount;
        req_op    = op;
        req_addr  = addr;
        req_data  = data;
        req_tag   = tag;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reqAccepted", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;

        got = 1'b0;
        gotData = '0;
        gotTag = '0;
        for (int c = 0; c < 300; c++) begin
            if (randomStall) begin
                mem_req_ready = ($urandom_range(0, 3) != 0);
                rsp_ready     = 1'($urandom_range(0, 1));
            end else begin
                mem_req_ready = 1'b1;
                rsp_ready     = 1'b1;
            end
            if (rsp_valid && rsp_ready) begin
                got = 1'b1;
                gotData = rsp_data;
                gotTag = rsp_tag;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        rsp_ready     = 1'b0;
        mem_req_ready = 1'b1;

        checkOutput("rspSeen", {31'd0, got}, 32'd1);
        checkOutput("rspData", gotData, expRsp);
        checkOutput("rspTag", {24'd0, gotTag}, {24'd0, tag});
        checkOutput("memReads", readCount - rd0, expRd);
        checkOutput("memWrites", writeCount - wr0, expWr);
        checkOutput("memWord", mem[idx], refMem[idx]);
        rspOut = gotData;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL globalTimeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] r;
        int          cyc;

        checks = 0;
        errors = 0;
        readCount = 0;
        writeCount = 0;
        resvValid = 1'b0;
        resvAddr = '0;
        pokeEn = 1'b0;
        pokeAddr = '0;
        pokeData = '0;
        reset = 1'b0;
        req_valid = 1'b0;
        req_op = '0;
        req_addr = '0;
        req_data = '0;
        req_tag = '0;
        rsp_ready = 1'b0;
        mem_req_ready = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("rstReqReady", {31'd0, req_ready}, 32'd1);
        checkOutput("rstMemReqValid", {31'd0, mem_req_valid}, 32'd0);
        checkOutput("rstRspValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rstMemRspReady", {31'd0, mem_rsp_ready}, 32'd0);
        checkOutput("rstRspData", rsp_data, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) pokeWord(8'(i), $urandom);

        // Latency: ADD 3 to mem[0x100]=5 with zero-wait memory.
        $display("[TB] latency test");
        pokeWord(8'h40, 32'd5);
        req_op = OpAdd;
        req_addr = 32'h100;
        req_data = 32'd3;
        req_tag = 8'h11;
        req_valid = 1'b1;
        cyc = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) break;
        end
        checkOutput("latency", cyc, 32'd4);
        checkOutput("latRspData", rsp_data, 32'd5);
        checkOutput("latRspTag", {24'd0, rsp_tag}, 32'h11);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("latReqReadyAfter", {31'd0, req_ready}, 32'd1);
        checkOutput("latMem", mem[8'h40], 32'd8);
        refMem[8'h40] = 32'd8;

        // Signed vs unsigned min/max on 0xFFFFFFFF.
        $display("[TB] min/max test");
        pokeWord(8'h20, 32'hFFFF_FFFF);
        applyStimulus(OpMin, 32'h80, 32'd1, 8'h21, 1'b0, r);
        checkOutput("minMem", mem[8'h20], 32'hFFFF_FFFF);
        pokeWord(8'h20, 32'hFFFF_FFFF);
        applyStimulus(OpMinu, 32'h80, 32'd1, 8'h22, 1'b0, r);
        checkOutput("minuMem", mem[8'h20], 32'd1);
        pokeWord(8'h20, 32'hFFFF_FFFF);
        applyStimulus(OpMaxu, 32'h80, 32'd1, 8'h23, 1'b0, r);
        checkOutput("maxuMem", mem[8'h20], 32'hFFFF_FFFF);

        // Back-pressure: mem_req_ready low 3 cycles in RD and WR, rsp_ready low 2 cycles.
        $display("[TB] stall test");
        pokeWord(8'h40, 32'd5);
        mem_req_ready = 1'b0;
        rsp_ready = 1'b0;
        req_op = OpAdd;
        req_addr = 32'h100;
        req_data = 32'd3;
        req_tag = 8'h5A;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkOutput("rdValid", {31'd0, mem_req_valid}, 32'd1);
            checkOutput("rdRw", {31'd0, mem_req_rw}, 32'd0);
            checkOutput("rdAddr", {2'd0, mem_req_addr}, 32'h40);
            checkOutput("rdReqReady", {31'd0, req_ready}, 32'd0);
            if (k < 2) @(negedge clk);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        checkOutput("waitRspReady", {31'd0, mem_rsp_ready}, 32'd1);
        mem_req_ready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput("wrValid", {31'd0, mem_req_valid}, 32'd1);
            checkOutput("wrRw", {31'd0, mem_req_rw}, 32'd1);
            checkOutput("wrData", mem_req_data, 32'd8);
            checkOutput("wrAddr", {2'd0, mem_req_addr}, 32'h40);
            checkOutput("wrReqReady", {31'd0, req_ready}, 32'd0);
            if (k < 2) @(negedge clk);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checkOutput("rspHoldValid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("rspHoldData", rsp_data, 32'd5);
            checkOutput("rspHoldTag", {24'd0, rsp_tag}, 32'h5A);
            checkOutput("rspHoldReqReady", {31'd0, req_ready}, 32'd0);
            if (k < 1) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("stallRspDone", {31'd0, rsp_valid}, 32'd0);
        checkOutput("stallReqReady", {31'd0, req_ready}, 32'd1);
        checkOutput("stallMem", mem[8'h40], 32'd8);
        refMem[8'h40] = 32'd8;

        // Illegal op: one read, no write, old value returned; next request still served.
        $display("[TB] illegal op test");
        pokeWord(8'h05, 32'h0BAD_F00D);
        applyStimulus(4'd15, 32'h14, 32'h1234, 8'h31, 1'b0, r);
        checkOutput("illegalRsp", r, 32'h0BAD_F00D);
        applyStimulus(OpAdd, 32'h14, 32'd1, 8'h32, 1'b0, r);
        checkOutput("afterIllegalMem", mem[8'h05], 32'h0BAD_F00E);

`ifdef AMO_LRSC_EN
        $display("[TB] LR/SC test");
        pokeWord(8'h10, 32'h77);
        applyStimulus(OpLr, 32'h40, 32'd0, 8'h40, 1'b0, r);
        checkOutput("lrRsp", r, 32'h77);
        applyStimulus(OpSc, 32'h40, 32'hCAFE, 8'h41, 1'b0, r);
        checkOutput("scOkRsp", r, 32'd0);
        checkOutput("scOkMem", mem[8'h10], 32'hCAFE);
        applyStimulus(OpSc, 32'h40, 32'hBEEF, 8'h42, 1'b0, r);
        checkOutput("scAgainRsp", r, 32'd1);
        applyStimulus(OpLr, 32'h40, 32'd0, 8'h43, 1'b0, r);
        applyStimulus(OpSwap, 32'h40, 32'h55, 8'h44, 1'b0, r);
        applyStimulus(OpSc, 32'h40, 32'h99, 8'h45, 1'b0, r);
        checkOutput("scAfterSwapRsp", r, 32'd1);
        checkOutput("scAfterSwapMem", mem[8'h10], 32'h55);
`else
        $display("[TB] LR/SC as illegal ops");
        pokeWord(8'h10, 32'h77);
        applyStimulus(OpLr, 32'h40, 32'd0, 8'h40, 1'b0, r);
        checkOutput("lrIllegalRsp", r, 32'h77);
        applyStimulus(OpSc, 32'h40, 32'hCAFE, 8'h41, 1'b0, r);
        checkOutput("scIllegalRsp", r, 32'h77);
        checkOutput("scIllegalMem", mem[8'h10], 32'h77);
`endif

        // Reset while waiting for read data: nothing written, engine recovers cleanly.
        $display("[TB] reset in WAIT test");
        pokeWord(8'h03, 32'h1234);
        mem_req_ready = 1'b1;
        req_op = OpAdd;
        req_addr = 32'h0C;
        req_data = 32'd1;
        req_tag = 8'h50;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("preRstRd", {31'd0, mem_req_valid}, 32'd1);
        @(negedge clk);
        checkOutput("preRstWait", {31'd0, mem_rsp_ready}, 32'd1);
        reset = 1'b0;
        resvValid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midRstReqReady", {31'd0, req_ready}, 32'd1);
        checkOutput("midRstMemReqValid", {31'd0, mem_req_valid}, 32'd0);
        checkOutput("midRstMemRspReady", {31'd0, mem_rsp_ready}, 32'd0);
        checkOutput("midRstRspValid", {31'd0, rsp_valid}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midRstMem", mem[8'h03], 32'h1234);
        applyStimulus(OpAdd, 32'h0C, 32'd1, 8'h51, 1'b0, r);
        checkOutput("postRstRsp", r, 32'h1234);

        // Random traffic with random back-pressure over a few words.
        $display("[TB] random test");
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            op = 4'($urandom_range(0, 15));
            a = {22'd0, 8'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            applyStimulus(op, a, $urandom, 8'($urandom), 1'b1, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
